sram_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one `sram_controller` between two 32-bit requesters, for example a CPU port and a DMA port. It sits directly in front of the controller's system-side interface. It turns each requester's level-held request into a single-cycle `memRead`/`memWrite` command, tracks the controller's `ready` busy/done handshake and returns read data with a one-cycle acknowledge. A watchdog counter returns an error acknowledge if the controller stalls.

---
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-requester round-robin front end for a single sram_controller.
// Each requester holds a level request. The arbiter latches the request fields, issues a
// single-cycle memRead/memWrite, follows the controller's ready low/high handshake and
// answers with a one-cycle ack. If the controller stalls, the watchdog answers with ack+err.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   rN_req/we/waddr/wdata    requester N command; held until rN_ack
//   rN_ack/err               requester N completion pulse / timeout flag (pulses with ack)
//   rN_rdata                 requester N registered read data; updated only by its reads
//   memRead/memWrite         single-cycle command to the controller
//   addrTarget/dataIn        latched halfword address and write data to the controller
//   dataOut/ready            controller read data and idle/done flag
//   busy/gnt_id              arbiter not idle / current (or most recent) owner
module sram_arbiter #(
    // Must be at least 1.
    parameter int unsigned TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_req,
    input  logic        r0_we,
    input  logic [7:0]  r0_waddr,
    input  logic [31:0] r0_wdata,
    output logic        r0_ack,
    output logic        r0_err,
    output logic [31:0] r0_rdata,
    input  logic        r1_req,
    input  logic        r1_we,
    input  logic [7:0]  r1_waddr,
    input  logic [31:0] r1_wdata,
    output logic        r1_ack,
    output logic        r1_err,
    output logic [31:0] r1_rdata,
    output logic        memRead,
    output logic        memWrite,
    output logic [8:0]  addrTarget,
    output logic [31:0] dataIn,
    input  logic [31:0] dataOut,
    input  logic        ready,
    output logic        busy,
    output logic        gnt_id
);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitLow, StWaitHigh, StResp} state_e;

    // Last wait cycle the watchdog allows; the abort happens on the edge that ends it.
    localparam logic [15:0] WdogLast = 16'(TIMEOUT_CYC - 1);

    state_e      state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        gnt_q, gnt_d;
    logic        we_q, we_d;
    logic [8:0]  addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [31:0] r0_rdata_q, r0_rdata_d;
    logic [31:0] r1_rdata_q, r1_rdata_d;
    logic        r0_ack_q, r0_ack_d;
    logic        r1_ack_q, r1_ack_d;
    logic        r0_err_q, r0_err_d;
    logic        r1_err_q, r1_err_d;
    logic [15:0] wdog_q, wdog_d;

    logic r0_elig, r1_elig;
    logic pick;
    logic wdog_hit;
    logic finish, timeout;

    // A requester being acked this cycle is still holding req; it must not win again yet.
    assign r0_elig  = r0_req & ~r0_ack_q;
    assign r1_elig  = r1_req & ~r1_ack_q;
    assign pick     = (r0_elig & r1_elig) ? ~last_gnt_q : r1_elig;
    assign wdog_hit = (wdog_q >= WdogLast);

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        data_d     = data_q;
        r0_rdata_d = r0_rdata_q;
        r1_rdata_d = r1_rdata_q;
        r0_ack_d   = 1'b0;
        r1_ack_d   = 1'b0;
        r0_err_d   = 1'b0;
        r1_err_d   = 1'b0;
        wdog_d     = wdog_q;
        finish     = 1'b0;
        timeout    = 1'b0;

        case (state_q)
            StIdle: begin
                if (ready && (r0_elig || r1_elig)) begin
                    gnt_d      = pick;
                    last_gnt_d = pick;
                    we_d       = pick ? r1_we : r0_we;
                    addr_d     = {(pick ? r1_waddr : r0_waddr), 1'b0};
                    data_d     = pick ? r1_wdata : r0_wdata;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                wdog_d  = '0;
                state_d = StWaitLow;
            end
            StWaitLow: begin
                wdog_d = wdog_q + 16'd1;
                if (wdog_hit) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                end else if (!ready) begin
                    state_d = StWaitHigh;
                end
            end
            StWaitHigh: begin
                wdog_d = wdog_q + 16'd1;
                if (wdog_hit) begin
                    finish  = 1'b1;
                    timeout = 1'b1;
                end else if (ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                finish = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (finish) begin
            state_d = StIdle;
            if (gnt_q) begin
                r1_ack_d = 1'b1;
                r1_err_d = timeout;
                if (!timeout && !we_q) r1_rdata_d = dataOut;
            end else begin
                r0_ack_d = 1'b1;
                r0_err_d = timeout;
                if (!timeout && !we_q) r0_rdata_d = dataOut;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            r0_rdata_q <= '0;
            r1_rdata_q <= '0;
            r0_ack_q   <= 1'b0;
            r1_ack_q   <= 1'b0;
            r0_err_q   <= 1'b0;
            r1_err_q   <= 1'b0;
            wdog_q     <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            r0_rdata_q <= r0_rdata_d;
            r1_rdata_q <= r1_rdata_d;
            r0_ack_q   <= r0_ack_d;
            r1_ack_q   <= r1_ack_d;
            r0_err_q   <= r0_err_d;
            r1_err_q   <= r1_err_d;
            wdog_q     <= wdog_d;
        end
    end

    assign memRead    = (state_q == StIssue) & ~we_q;
    assign memWrite   = (state_q == StIssue) & we_q;
    assign busy       = (state_q != StIdle);
    assign gnt_id     = gnt_q;
    assign addrTarget = addr_q;
    assign dataIn     = data_q;
    assign r0_ack     = r0_ack_q;
    assign r1_ack     = r1_ack_q;
    assign r0_err     = r0_err_q;
    assign r1_err     = r1_err_q;
    assign r0_rdata   = r0_rdata_q;
    assign r1_rdata   = r1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_req, r0_we, r1_req, r1_we;
    logic [7:0]  r0_waddr, r1_waddr;
    logic [31:0] r0_wdata, r1_wdata;
    logic        r0_ack, r0_err, r1_ack, r1_err;
    logic [31:0] r0_rdata, r1_rdata;
    logic        memRead, memWrite, busy, gnt_id;
    logic [8:0]  addrTarget;
    logic [31:0] dataIn, dataOut;
    logic        ready;

    int n_pass = 0;
    int n_total = 0;

    // Controller stub controls
    logic        stub_init = 1'b1;
    logic        stub_dead = 1'b0;
    int          stub_lat = 2;
    logic        bd_we = 1'b0;
    logic [7:0]  bd_addr = 8'd0;
    logic [31:0] bd_data = 32'd0;

    logic [31:0] mem [256];
    int          cnt;
    logic        pend_we;
    logic [7:0]  pend_a;
    logic [31:0] pend_d;

    always #5 clk = ~clk;

    sram_arbiter #(.TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_waddr(r0_waddr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_waddr(r1_waddr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .memRead(memRead), .memWrite(memWrite), .addrTarget(addrTarget), .dataIn(dataIn),
        .dataOut(dataOut), .ready(ready), .busy(busy), .gnt_id(gnt_id)
    );

    // Controller stub: takes the command on the edge ending ISSUE, holds ready low for
    // stub_lat cycles, then raises ready with the read data on dataOut.
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        if (stub_init) begin
            ready   <= 1'b1;
            dataOut <= 32'd0;
            cnt     <= 0;
            pend_we <= 1'b0;
            pend_a  <= 8'd0;
            pend_d  <= 32'd0;
        end else if (ready && !stub_dead && (memRead || memWrite)) begin
            ready   <= 1'b0;
            cnt     <= stub_lat;
            pend_we <= memWrite;
            pend_a  <= addrTarget[8:1];
            pend_d  <= dataIn;
        end else if (!ready) begin
            if (cnt <= 1) begin
                ready <= 1'b1;
                if (pend_we) mem[pend_a] <= pend_d;
                else dataOut <= mem[pend_a];
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    task automatic backdoor(input logic [7:0] a, input logic [31:0] d);
        bd_addr = a;
        bd_data = d;
        bd_we   = 1'b1;
        @(negedge clk);
        bd_we   = 1'b0;
    endtask

    task automatic reset_dut();
        rst    = 1'b0;
        r0_req = 1'b0;
        r1_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Waits until every raised request has been acked, dropping each req in its ack cycle.
    task automatic wait_acks(input int limit, output int a0, output int a1);
        bit done;
        a0 = 0;
        a1 = 0;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(negedge clk);
            if (r0_ack) begin a0++; r0_req = 1'b0; end
            if (r1_ack) begin a1++; r1_req = 1'b0; end
            if (!r0_req && !r1_req) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; stub_init = 1'b1;
        r0_req = 1'b0; r0_we = 1'b0; r0_waddr = 8'd0; r0_wdata = 32'd0;
        r1_req = 1'b0; r1_we = 1'b0; r1_waddr = 8'd0; r1_wdata = 32'd0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({busy, gnt_id, memRead, memWrite} !== 4'b0000)
            $display("FAIL reset_ctrl: got %b want 0000", {busy, gnt_id, memRead, memWrite});
        else n_pass++;
        n_total++;
        if ({r0_ack, r0_err, r1_ack, r1_err} !== 4'b0000)
            $display("FAIL reset_ack: got %b want 0000", {r0_ack, r0_err, r1_ack, r1_err});
        else n_pass++;
        n_total++;
        if ({addrTarget, dataIn} !== 41'd0)
            $display("FAIL reset_addr_data: got %h/%h want 0/0", addrTarget, dataIn);
        else n_pass++;
        n_total++;
        if ({r0_rdata, r1_rdata} !== 64'd0)
            $display("FAIL reset_rdata: got %h/%h want 0/0", r0_rdata, r1_rdata);
        else n_pass++;
        stub_init = 1'b0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_read();
        int lat, nrd, nwr;
        logic [13:0] issue_obs;
        backdoor(8'd5, 32'hDEADBEEF);
        r0_we = 1'b0; r0_waddr = 8'd5; r0_wdata = 32'd0; r0_req = 1'b1;
        lat = 0; nrd = 0; nwr = 0; issue_obs = '0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (i == 1) issue_obs = {busy, gnt_id, memRead, memWrite, 1'b0, addrTarget};
            if (memRead) nrd++;
            if (memWrite) nwr++;
            if (r0_ack) lat = i;
        end
        n_total++;
        if (issue_obs !== {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 9'd10})
            $display("FAIL read_issue: got %h want %h", issue_obs, {5'b10100, 9'd10});
        else n_pass++;
        n_total++;
        if (lat != 6) $display("FAIL read_latency: got %0d want 6", lat);
        else n_pass++;
        n_total++;
        if (r0_rdata !== 32'hDEADBEEF) $display("FAIL read_data: got %h want deadbeef", r0_rdata);
        else n_pass++;
        n_total++;
        if (nrd != 1 || nwr != 0 || r0_err !== 1'b0)
            $display("FAIL read_pulses: got rd=%0d wr=%0d err=%b want 1 0 0", nrd, nwr, r0_err);
        else n_pass++;
        r0_req = 1'b0;
        @(negedge clk);
        n_total++;
        if (r0_ack !== 1'b0 || busy !== 1'b0)
            $display("FAIL read_ack_single: got ack=%b busy=%b want 0 0", r0_ack, busy);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        int order[2];
        int nack, nwr, nrd, a0, a1;
        bit chk_b2b;
        logic [42:0] b2b;
        reset_dut();
        r0_we = 1'b1; r0_waddr = 8'd1; r0_wdata = 32'h11111111;
        r1_we = 1'b1; r1_waddr = 8'd2; r1_wdata = 32'h22222222;
        r0_req = 1'b1; r1_req = 1'b1;
        nack = 0; nwr = 0; nrd = 0; chk_b2b = 1'b0; b2b = '0;
        order[0] = -1; order[1] = -1;
        for (int i = 0; i < 60 && nack < 2; i++) begin
            @(negedge clk);
            if (memWrite) nwr++;
            if (memRead) nrd++;
            if (chk_b2b) begin
                chk_b2b = 1'b0;
                b2b = {memWrite, gnt_id, addrTarget, dataIn};
            end
            if (r0_ack) begin r0_req = 1'b0; order[nack] = 0; nack++; chk_b2b = 1'b1; end
            if (r1_ack && nack < 2) begin r1_req = 1'b0; order[nack] = 1; nack++; end
        end
        n_total++;
        if (nack != 2 || order[0] != 0 || order[1] != 1)
            $display("FAIL sim_order: got n=%0d %0d,%0d want 2 0,1", nack, order[0], order[1]);
        else n_pass++;
        n_total++;
        if (nwr != 2 || nrd != 0) $display("FAIL sim_pulses: got wr=%0d rd=%0d want 2 0", nwr, nrd);
        else n_pass++;
        n_total++;
        if (b2b !== {1'b1, 1'b1, 9'd4, 32'h22222222})
            $display("FAIL back_to_back: got %h want %h", b2b, {2'b11, 9'd4, 32'h22222222});
        else n_pass++;
        r0_we = 1'b0; r0_waddr = 8'd2;
        r1_we = 1'b0; r1_waddr = 8'd1;
        r0_req = 1'b1; r1_req = 1'b1;
        wait_acks(60, a0, a1);
        n_total++;
        if (a0 != 1 || a1 != 1) $display("FAIL readback_acks: got %0d/%0d want 1/1", a0, a1);
        else n_pass++;
        n_total++;
        if (r0_rdata !== 32'h22222222 || r1_rdata !== 32'h11111111)
            $display("FAIL readback_data: got %h/%h want 22222222/11111111", r0_rdata, r1_rdata);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int grants[6];
        int nissue;
        reset_dut();
        r0_we = 1'b0; r0_waddr = 8'd2;
        r1_we = 1'b0; r1_waddr = 8'd1;
        r0_req = 1'b1; r1_req = 1'b1;
        nissue = 0;
        for (int i = 0; i < 100 && nissue < 6; i++) begin
            @(negedge clk);
            if (memRead || memWrite) begin
                grants[nissue] = int'(gnt_id);
                nissue++;
            end
        end
        r0_req = 1'b0; r1_req = 1'b0;
        n_total++;
        if (nissue != 6) $display("FAIL rr_count: got %0d want 6", nissue);
        else n_pass++;
        for (int k = 0; k < nissue; k++) begin
            n_total++;
            if (grants[k] != (k % 2)) $display("FAIL rr_grant%0d: got %0d want %0d", k, grants[k], k % 2);
            else n_pass++;
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_write_keeps_rdata();
        int a0, a1;
        backdoor(8'd9, 32'hCAFEF00D);
        r1_we = 1'b0; r1_waddr = 8'd9; r1_wdata = 32'd0; r1_req = 1'b1;
        wait_acks(40, a0, a1);
        n_total++;
        if (a1 != 1 || r1_rdata !== 32'hCAFEF00D)
            $display("FAIL r1_read: got ack=%0d data=%h want 1 cafef00d", a1, r1_rdata);
        else n_pass++;
        r1_we = 1'b1; r1_wdata = 32'd0; r1_req = 1'b1;
        wait_acks(40, a0, a1);
        n_total++;
        if (a1 != 1 || r1_rdata !== 32'hCAFEF00D)
            $display("FAIL write_keeps_rdata: got ack=%0d data=%h want 1 cafef00d", a1, r1_rdata);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (mem[9] !== 32'd0 || r1_rdata !== 32'hCAFEF00D)
            $display("FAIL write_effect: got mem=%h rdata=%h want 0 cafef00d", mem[9], r1_rdata);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int lat, nrd;
        logic err_at_ack;
        stub_dead = 1'b1;
        r0_we = 1'b0; r0_waddr = 8'd3; r0_req = 1'b1;
        lat = 0; nrd = 0; err_at_ack = 1'b0;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (memRead) nrd++;
            if (r0_ack) begin lat = i; err_at_ack = r0_err; r0_req = 1'b0; end
        end
        r0_req = 1'b0;
        n_total++;
        if (lat != 10) $display("FAIL timeout_latency: got %0d want 10", lat);
        else n_pass++;
        n_total++;
        if (err_at_ack !== 1'b1) $display("FAIL timeout_err: got %b want 1", err_at_ack);
        else n_pass++;
        n_total++;
        if (r0_rdata !== 32'h22222222 || nrd != 1)
            $display("FAIL timeout_rdata: got %h rd=%0d want 22222222 1", r0_rdata, nrd);
        else n_pass++;
        stub_dead = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, r0_ack, r0_err} !== 3'b000)
            $display("FAIL timeout_after: got %b want 000", {busy, r0_ack, r0_err});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nack, a0, a1;
        logic mid;
        stub_lat = 5;
        r1_we = 1'b0; r1_waddr = 8'd1; r1_req = 1'b1;
        repeat (3) @(negedge clk);
        mid = busy & ~memRead & ~memWrite;
        n_total++;
        if (mid !== 1'b1) $display("FAIL mid_access: got %b want 1", mid);
        else n_pass++;
        rst = 1'b0;
        r1_req = 1'b0;
        @(negedge clk);
        n_total++;
        if ({busy, gnt_id, memRead, memWrite, r0_ack, r0_err, r1_ack, r1_err} !== 8'd0)
            $display("FAIL mid_reset_ctrl: got %b want 0",
                     {busy, gnt_id, memRead, memWrite, r0_ack, r0_err, r1_ack, r1_err});
        else n_pass++;
        n_total++;
        if ({addrTarget, dataIn, r0_rdata, r1_rdata} !== 105'd0)
            $display("FAIL mid_reset_data: got %h %h %h %h want 0",
                     addrTarget, dataIn, r0_rdata, r1_rdata);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        nack = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (r0_ack || r1_ack) nack++;
        end
        n_total++;
        if (nack != 0) $display("FAIL mid_no_ack: got %0d want 0", nack);
        else n_pass++;
        stub_lat = 2;
        r0_we = 1'b0; r0_waddr = 8'd2; r0_req = 1'b1;
        wait_acks(40, a0, a1);
        n_total++;
        if (a0 != 1 || r0_rdata !== 32'h22222222 || r0_err !== 1'b0)
            $display("FAIL post_reset_read: got ack=%0d data=%h err=%b want 1 22222222 0",
                     a0, r0_rdata, r0_err);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_simultaneous();
        test_round_robin();
        test_write_keeps_rdata();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish want finish within 200us");
        $fatal(1, "simulation time limit");
    end

endmodule
